// File: rtl/sync_stream_fifo_pkg.sv
// Shared types and helpers for the single-clock stream FIFO.
package sync_stream_fifo_pkg;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam fifo_status_t FifoStatusRst = '{
        full:         1'b0,
        almost_full:  1'b0,
        empty:        1'b1,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    // Extra MSB is the wrap bit distinguishing full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic to01(input logic b);
        return (b === 1'b1);
    endfunction

endpackage

// File: rtl/sync_stream_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
module sync_stream_fifo_ram
    import sync_stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = ptr_width(DEPTH) - 1
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_stream_fifo.sv
// Single-clock stream FIFO with count, threshold flags, flush and sticky errors.
// Define SYNC_STREAM_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_stream_fifo
    import sync_stream_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH     = 8,
    parameter int unsigned FIFO_BUFFER_SIZE    = 8,
    parameter int unsigned ALMOST_FULL_THRESH  = FIFO_BUFFER_SIZE - 2,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0]        din,
    output logic                              full,
    output logic                              almost_full,
    input  logic                              rd_en,
    output logic [FIFO_DATA_WIDTH-1:0]        dout,
    output logic                              dout_valid,
    output logic                              empty,
    output logic                              almost_empty,
    output logic [$clog2(FIFO_BUFFER_SIZE):0] count,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int unsigned PW = ptr_width(FIFO_BUFFER_SIZE);
    localparam int unsigned AW = PW - 1;
    localparam logic [PW-1:0] DepthCnt = PW'(FIFO_BUFFER_SIZE);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    fifo_status_t  status_q, status_d;

    logic                       hold_off;
    logic                       wr_acc;
    logic                       pop;
    logic                       ram_rd_en;
    logic                       empty_nxt;
    logic [FIFO_DATA_WIDTH-1:0] ram_rdata;
    logic [FIFO_DATA_WIDTH-1:0] ram_rdata_clean;

    assign hold_off = reset | flush;
    assign wr_acc   = wr_en & ~status_q.full & ~hold_off;

    sync_stream_fifo_ram #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .DEPTH      (FIFO_BUFFER_SIZE),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (din),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (ram_rdata)
    );

    always_comb begin
        ram_rdata_clean = '0;
        for (int unsigned i = 0; i < FIFO_DATA_WIDTH; i++) begin
            ram_rdata_clean[i] = to01(ram_rdata[i]);
        end
    end

`ifdef SYNC_STREAM_FIFO_FWFT_EN
    // Two-stage head pipeline: RAM read register (in flight) then prefetch register.
    logic                       inflight_q, inflight_d;
    logic                       pf_valid_q, pf_valid_d;
    logic [FIFO_DATA_WIDTH-1:0] pf_data_q, pf_data_d;
    logic                       move;

    always_comb begin
        pop        = rd_en & pf_valid_q & ~hold_off;
        move       = inflight_q & (~pf_valid_q | pop);
        ram_rd_en  = (wr_ptr_q != rd_ptr_q) & (~inflight_q | move) & ~hold_off;
        pf_valid_d = pf_valid_q & ~pop;
        pf_data_d  = pf_data_q;
        if (move) begin
            pf_valid_d = 1'b1;
            pf_data_d  = ram_rdata_clean;
        end
        inflight_d = ram_rd_en | (inflight_q & ~move);
        if (flush) begin
            pf_valid_d = 1'b0;
            inflight_d = 1'b0;
        end
        empty_nxt = ~pf_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            pf_valid_q <= 1'b0;
            pf_data_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            pf_valid_q <= pf_valid_d;
            pf_data_q  <= pf_data_d;
        end
    end

    assign dout       = pf_data_q;
    assign dout_valid = pf_valid_q;
`else
    logic dout_valid_q, dout_valid_d;
    logic rd_seen_q, rd_seen_d;

    // dout reads straight off the RAM read register; rd_seen_q gives it a zero reset value.
    always_comb begin
        pop          = rd_en & ~status_q.empty & ~hold_off;
        ram_rd_en    = pop;
        dout_valid_d = pop;
        rd_seen_d    = rd_seen_q | pop;
        empty_nxt    = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_valid_q <= 1'b0;
            rd_seen_q    <= 1'b0;
        end else begin
            dout_valid_q <= dout_valid_d;
            rd_seen_q    <= rd_seen_d;
        end
    end

    assign dout       = rd_seen_q ? ram_rdata_clean : '0;
    assign dout_valid = dout_valid_q;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (ram_rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Flags track count_d so they change on the same edge as count.
    always_comb begin
        status_d              = status_q;
        status_d.full         = (count_d == DepthCnt);
        status_d.almost_full  = (32'(count_d) >= ALMOST_FULL_THRESH);
        status_d.empty        = empty_nxt;
        status_d.almost_empty = (32'(count_d) <= ALMOST_EMPTY_THRESH);
        status_d.overflow     = status_q.overflow | (wr_en & status_q.full & ~hold_off);
        status_d.underflow    = status_q.underflow | (rd_en & status_q.empty & ~hold_off);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= FifoStatusRst;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    assign count        = count_q;
    assign full         = status_q.full;
    assign almost_full  = status_q.almost_full;
    assign empty        = status_q.empty;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = status_q.overflow;
    assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_sync_stream_fifo.sv
// Self-checking bench for sync_stream_fifo: queue-based reference model plus directed pins.
module tb_sync_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset, flush, wr_en, rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full, almost_full, empty, almost_empty, dout_valid, overflow, underflow;
    logic [3:0]    count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_dout = '0;
    bit            exp_dv = 1'b0, exp_ovf = 1'b0, exp_udf = 1'b0;

    sync_stream_fifo #(
        .FIFO_DATA_WIDTH     (DW),
        .FIFO_BUFFER_SIZE    (DEPTH),
        .ALMOST_FULL_THRESH  (DEPTH - 2),
        .ALMOST_EMPTY_THRESH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit f, input bit w, input logic [DW-1:0] d,
                              input bit rd);
        int n;
        n = mq.size();
        if (r) begin
            mq.delete();
            exp_dout = '0;
            exp_dv   = 1'b0;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
        end else if (f) begin
            mq.delete();
            exp_dv = 1'b0;
        end else begin
            exp_dv = 1'b0;
            if (w && n == DEPTH) exp_ovf = 1'b1;
            if (rd && n == 0) exp_udf = 1'b1;
            if (rd && n != 0) begin
                exp_dout = mq.pop_front();
                exp_dv   = 1'b1;
            end
            if (w && n != DEPTH) mq.push_back(d);
        end
    endtask

    task automatic cyc(input bit r, input bit f, input bit w, input logic [DW-1:0] d,
                       input bit rd);
        reset = r;
        flush = f;
        wr_en = w;
        din   = d;
        rd_en = rd;
        @(posedge clk);
        model_edge(r, f, w, d, rd);
        #1;
    endtask

    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            n = mq.size();
            check("count", 32'(count), 32'(n));
            check("full", 32'(full), 32'(n == DEPTH));
            check("almost_full", 32'(almost_full), 32'(n >= DEPTH - 2));
            check("empty", 32'(empty), 32'(n == 0));
            check("almost_empty", 32'(almost_empty), 32'(n <= 2));
            check("overflow", 32'(overflow), 32'(exp_ovf));
            check("underflow", 32'(underflow), 32'(exp_udf));
            check("dout_valid", 32'(dout_valid), 32'(exp_dv));
            check("dout", 32'(dout), 32'(exp_dout));
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_almost_empty"}, 32'(almost_empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_almost_full"}, 32'(almost_full), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_underflow"}, 32'(underflow), 0);
        check({tag, "_dout"}, 32'(dout), 0);
        check({tag, "_dout_valid"}, 32'(dout_valid), 0);
    endtask

    initial begin
        cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);
        check_reset_state("rst");

`ifdef SYNC_STREAM_FIFO_FWFT_EN
        cyc(0, 0, 1, 8'h5C, 0);
        check("fwft_e0_empty", 32'(empty), 1);
        check("fwft_e0_count", 32'(count), 1);
        cyc(0, 0, 0, 8'h00, 0);
        check("fwft_e1_empty", 32'(empty), 1);
        cyc(0, 0, 0, 8'h00, 0);
        check("fwft_e2_empty", 32'(empty), 0);
        check("fwft_e2_dout", 32'(dout), 32'h5C);
        check("fwft_e2_dout_valid", 32'(dout_valid), 1);
        cyc(0, 0, 0, 8'h00, 1);
        check("fwft_pop_empty", 32'(empty), 1);
        check("fwft_pop_count", 32'(count), 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 4; i++) begin
            int guard;
            guard = 0;
            while (empty && guard < 10) begin
                cyc(0, 0, 0, 8'h00, 0);
                guard++;
            end
            check("fwft_seq_dout", 32'(dout), 32'(8'h40 + i));
            cyc(0, 0, 0, 8'h00, 1);
        end
        check("fwft_seq_count", 32'(count), 0);
`else
        chk_en = 1'b1;

        // Fill 0x01..0x08, then overflow
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1, 8'(i), 0);
            check("fill_count", 32'(count), 32'(i));
            check("fill_almost_full", 32'(almost_full), 32'(i >= 6));
            check("fill_full", 32'(full), 32'(i == 8));
        end
        cyc(0, 0, 1, 8'h99, 0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(count), 8);

        // Drain, then underflow
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 0, 8'h00, 1);
            check("drain_dout", 32'(dout), 32'(i));
            check("drain_dout_valid", 32'(dout_valid), 1);
            check("drain_empty", 32'(empty), 32'(i == 8));
        end
        cyc(0, 0, 0, 8'h00, 1);
        check("udf_flag", 32'(underflow), 1);
        check("udf_dout_valid", 32'(dout_valid), 0);
        check("udf_dout_hold", 32'(dout), 32'h08);

        // Streaming across pointer wraps with preload of 3
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'(8'hF0 + i), 0);
        for (int k = 0; k < 40; k++) begin
            cyc(0, 0, 1, 8'(k), 1);
            check("stream_count", 32'(count), 3);
            check("stream_dout", 32'(dout), (k < 3) ? 32'(8'hF0 + k) : 32'(k - 3));
            check("stream_dout_valid", 32'(dout_valid), 1);
        end

        // Randomized traffic: write-heavy then read-heavy, occasional flush/reset
        for (int c = 0; c < 800; c++) begin
            bit w, rd, f, r;
            int wb;
            wb = (c < 400) ? 70 : 30;
            w  = ($urandom_range(0, 99) < wb);
            rd = ($urandom_range(0, 99) < 100 - wb);
            f  = ($urandom_range(0, 99) < 2);
            r  = ($urandom_range(0, 299) == 0);
            cyc(r, f, w, 8'($urandom), rd);
        end

        // Flush with a concurrent write; sticky flags must survive
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'(8'h10 + i), 0);
        check("pre_flush_count", 32'(count), 5);
        cyc(0, 1, 1, 8'h77, 0);
        check("flush_count", 32'(count), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_underflow", 32'(underflow), 1);
        check("flush_overflow", 32'(overflow), 0);
        cyc(0, 0, 1, 8'h33, 0);
        cyc(0, 0, 0, 8'h00, 1);
        check("post_flush_dout", 32'(dout), 32'h33);

        // Reset with count 4 and overflow set
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 8'(8'h20 + i), 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 1);
        check("pre_rst_count", 32'(count), 4);
        check("pre_rst_overflow", 32'(overflow), 1);
        cyc(1, 0, 0, 8'h00, 0);
        check_reset_state("rst2");
        cyc(0, 0, 1, 8'hAA, 0);
        cyc(0, 0, 0, 8'h00, 1);
        check("rst2_readback", 32'(dout), 32'hAA);
        check("rst2_readback_valid", 32'(dout_valid), 1);
        @(negedge clk);
        chk_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_stream_fifo.md
Name: sync_stream_fifo

Overview:
- Single-clock, parametrised successor to the inter-stage pixel FIFOs between image-pipeline stages (e.g. greyscale to subtractor).
- Adds the following over the previous generation:
  - occupancy count
  - programmable almost-full/almost-empty flags
  - synchronous flush
  - sticky overflow/underflow error flags
  - read-data valid strobe
- Optional first-word-fall-through read mode.

Parameters:
- FIFO_DATA_WIDTH, 8, data word width in bits (>=1).
- FIFO_BUFFER_SIZE, 8, depth in words; power of two, >=2.
- ALMOST_FULL_THRESH, FIFO_BUFFER_SIZE-2, almost_full asserts when count >= this value.
- ALMOST_EMPTY_THRESH, 2, almost_empty asserts when count <= this value.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents; error flags are kept.
- wr_en  in  1  write request.
- din  in  FIFO_DATA_WIDTH  write data.
- full  out  1  count == FIFO_BUFFER_SIZE.
- almost_full  out  1  count >= ALMOST_FULL_THRESH.
- rd_en  in  1  read request.
- dout  out  FIFO_DATA_WIDTH  read data.
- dout_valid  out  1  dout holds a freshly popped word (standard mode).
- empty  out  1  count == 0 (standard mode); no word presented (FWFT mode).
- almost_empty  out  1  count <= ALMOST_EMPTY_THRESH.
- count  out  $clog2(FIFO_BUFFER_SIZE)+1  occupancy, 0..FIFO_BUFFER_SIZE.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk; it has priority over all other inputs.
- Reset values:
  - rd/wr pointers 0, count 0, dout 0, dout_valid 0.
  - empty 1, almost_empty 1, full 0, almost_full 0.
  - overflow 0, underflow 0.
  - RAM contents not reset.
- Pointers: width $clog2(FIFO_BUFFER_SIZE)+1; MSB is the wrap bit, low bits address the RAM. Pointers increment modulo 2*FIFO_BUFFER_SIZE.
- Write accepted: wr_en && !full, evaluated on the pre-edge full. A write while full is dropped, memory unchanged, overflow set.
- Read accepted: rd_en && !empty, evaluated on the pre-edge empty. A read while empty is ignored and underflow set.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Write attempt while full, with a read accepted in the same cycle: the write is still rejected (no pass-through), overflow set.
- Full and empty status:
  - full, empty, almost_full and almost_empty are registered.
  - They reflect count after the current edge, so a flag changes on the same edge as count.
- Standard read mode:
  - dout is registered; on an accepted read, dout = RAM[rd_ptr] on the next edge.
  - dout_valid = 1 for exactly that cycle; otherwise dout holds its last value and dout_valid = 0.
  - Read latency is one cycle.
- X sanitisation: any non-0/1 bit read from the RAM is driven to 0 on dout (X-to-0 sanitisation retained).
- flush (and not reset): pointers, count and flags go to their reset values on the next edge. Any wr_en/rd_en in the flush cycle is ignored. dout_valid = 0. dout, overflow and underflow hold.
- Sticky flags: overflow and underflow clear only on reset.
- Threshold flags: almost_full and almost_empty may both be 1 when the thresholds overlap; this is legal.

Optional Feature:
- Macro: SYNC_STREAM_FIFO_FWFT_EN.
- Defined (first-word-fall-through mode):
  - A one-word prefetch register holds the head word.
  - dout shows the head word whenever empty = 0; rd_en pops it.
  - Latency from first write to empty deasserting is 2 cycles (RAM read plus prefetch).
  - dout_valid is tied to !empty.
  - Total capacity stays FIFO_BUFFER_SIZE, and count includes the prefetched word.
- Undefined: standard registered-read mode as specified above.

Decomposition:
- Package sync_stream_fifo_pkg:
  - function ptr_width(depth) returning $clog2(depth)+1.
  - function to01 for X sanitisation.
  - typedef fifo_status_t: struct packed of full, almost_full, empty, almost_empty, overflow, underflow.
- Sub-module sync_stream_fifo_ram: simple dual-port RAM with synchronous write, synchronous read and read enable, parametrised width and depth. The top level holds pointers, count, flags and the FWFT prefetch.

Test Plan:
- Reset, then write 8 words 0x01..0x08 at depth 8:
  - count 1..8; almost_full at count 6; full at count 8.
  - A 9th write sets overflow=1, count stays 8.
- From full, read 8 in a row:
  - dout 0x01..0x08, each one cycle after rd_en, with dout_valid pulses.
  - empty on the edge of the 8th read; a 9th read sets underflow=1.
- Continuous write+read every cycle for 40 cycles with a ramp 0x00..0x27:
  - Output ordering is preserved across 5 pointer wraps.
  - count is constant at the preload value 3.
- Fill to 5, assert flush with wr_en=1: next cycle count=0, empty=1, the write is ignored, overflow/underflow unchanged.
- Assert reset while count=4 and overflow=1: all outputs return to reset values on the next edge; a subsequent write of 0xAA reads back as 0xAA.
- Build with SYNC_STREAM_FIFO_FWFT_EN and write 0x5C:
  - empty deasserts 2 cycles later with dout=0x5C before any rd_en.
  - rd_en pops it: empty=1, count=0.
